// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory port between I-cache fills and D-cache fills/writebacks
// Ports:
//   clk, rst (sync, active-low)
//   i_req/i_addr -> i_rdata/i_done          : I-cache line fill
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done : D-cache fill (d_we=0) or writeback (d_we=1)
//   mem_re/mem_we/mem_addr/mem_wdata, mem_rdata/mem_rdy : memory port
//   err   : watchdog-abort pulse, coincident with done
//   owner : 00 idle, 01 I busy, 10 D busy, 11 response cycle
module cache_mem_arbiter #(
  parameter int LINE_W = 64,
  parameter int TIMEOUT = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [15:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              err,
  output logic [1:0]        owner
);
  localparam int WW = $clog2(TIMEOUT);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, I_BUSY = 2'b01, D_BUSY = 2'b10, RESP = 2'b11} state_t;
  state_t state, state_n;
  logic [SW-1:0] streak, streak_n;
  logic [WW-1:0] wdog, wdog_n;
  logic re_n, we_n, i_done_n, d_done_n, err_n, d_go, tout;
  logic [15:0] addr_n;
  logic [LINE_W-1:0] wdata_n, i_rdata_n, d_rdata_n;
  // D wins unless I is waiting and D has used up its streak allowance
  assign d_go = d_req & (~i_req | (streak < SW'(MAX_D_STREAK)));
  assign tout = wdog == WW'(TIMEOUT - 1);
  assign owner = state;
  always_comb begin
    state_n = state;
    streak_n = streak;
    wdog_n = wdog;
    re_n = mem_re;
    we_n = mem_we;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    i_done_n = 1'b0;
    d_done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        if (d_go) begin
          state_n = D_BUSY;
          addr_n = d_addr;
          we_n = d_we;
          re_n = ~d_we;
          wdata_n = d_wdata;
          // d_go with i_req pending guarantees streak < MAX_D_STREAK, so +1 saturates naturally
          streak_n = i_req ? streak + 1'b1 : '0;
        end else if (i_req) begin
          state_n = I_BUSY;
          addr_n = i_addr;
          re_n = 1'b1;
          we_n = 1'b0;
          streak_n = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        wdog_n = wdog + 1'b1;
        if (mem_rdy | tout) begin
          state_n = RESP;
          re_n = 1'b0;
          we_n = 1'b0;
          err_n = ~mem_rdy;
          i_done_n = state == I_BUSY;
          d_done_n = state == D_BUSY;
          i_rdata_n = state == I_BUSY ? (mem_rdy ? mem_rdata : '0) : i_rdata;
          d_rdata_n = state == D_BUSY ? ((mem_rdy & ~mem_we) ? mem_rdata : '0) : d_rdata;
        end
      end
      default: begin
        state_n = IDLE;
        wdog_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      streak <= '0;
      wdog <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      streak <= streak_n;
      wdog <= wdog_n;
      mem_re <= re_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      i_rdata <= i_rdata_n;
      d_rdata <= d_rdata_n;
      i_done <= i_done_n;
      d_done <= d_done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with a latency-programmable memory model
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_rdy = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0, mem_rdata = '0;
  logic [63:0] i_rdata, d_rdata, mem_wdata;
  logic i_done, d_done, mem_re, mem_we, err;
  logic [15:0] mem_addr;
  logic [1:0] owner;
  int checks = 0, errors = 0;
  int cnt = 0, last_len = 0, rdy_lat = 0;
  logic force_rdy = 1'b0;
  logic [63:0] rdata_val = '0;
  logic [81:0] g_q[$];
  logic [98:0] d_q[$];

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_g(input logic we, input logic [15:0] addr, input logic [63:0] wd);
    g_q.push_back({we, ~we, addr, we ? wd : 64'h0});
  endtask

  task automatic push_d(input logic is_d, input logic [63:0] data, input logic er, input int len);
    d_q.push_back({is_d, ~is_d, data, er, len[31:0]});
  endtask

  // one cycle: memory model, grant/done scoreboard, and requesters dropping req on done
  task automatic tick();
    logic [81:0] g;
    logic [98:0] e;
    @(negedge clk);
    if (mem_re | mem_we) begin
      cnt++;
      if (cnt == 1) begin
        if (g_q.size() == 0) chk("grant_extra", {mem_we, mem_re, mem_addr}, 0);
        else begin
          g = g_q.pop_front();
          chk("grant", {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 64'h0}, g);
        end
      end
      mem_rdy = force_rdy | (rdy_lat != 0 && cnt == rdy_lat);
    end else begin
      if (cnt != 0) last_len = cnt;
      cnt = 0;
      mem_rdy = force_rdy;
    end
    mem_rdata = rdata_val;
    if (i_done | d_done) begin
      if (d_q.size() == 0) chk("done_extra", {i_done, d_done, err}, 0);
      else begin
        e = d_q.pop_front();
        chk("done", {d_done, i_done, d_done ? d_rdata : i_rdata, err, last_len[31:0]}, e);
      end
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((d_q.size() != 0 || g_q.size() != 0 || owner != 2'b00) && n < 500);
    chk(tag, n < 500, 1);
  endtask

  initial begin
    tick();
    tick();
    tick();
    chk("reset_zero", {mem_re, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_done, d_done, err, owner}, 0);
    rst = 1'b1;
    tick();
    // single I fill, memory answers on the 3rd busy cycle
    i_addr = 16'h0040; rdata_val = 64'hA5; rdy_lat = 3;
    push_g(1'b0, 16'h0040, 0);
    push_d(1'b0, 64'hA5, 1'b0, 3);
    i_req = 1'b1;
    wait_quiet("t1_timeout");
    // simultaneous: D writeback first, then I
    i_addr = 16'h0080; d_addr = 16'h1000; d_we = 1'b1; d_wdata = 64'h0123_4567_89AB_CDEF; rdata_val = 64'h5A5A;
    push_g(1'b1, 16'h1000, 64'h0123_4567_89AB_CDEF);
    push_g(1'b0, 16'h0080, 0);
    push_d(1'b1, 64'h0, 1'b0, 3);
    push_d(1'b0, 64'h5A5A, 1'b0, 3);
    d_req = 1'b1; i_req = 1'b1;
    wait_quiet("t2_timeout");
    // streak limit: D re-requests continuously while I waits
    i_addr = 16'h0200; d_addr = 16'h0100; d_we = 1'b0; rdata_val = 64'hCAFE; rdy_lat = 1;
    for (int k = 0; k < 4; k++) push_g(1'b0, 16'h0100, 0);
    push_g(1'b0, 16'h0200, 0);
    push_g(1'b0, 16'h0100, 0);
    for (int k = 0; k < 4; k++) push_d(1'b1, 64'hCAFE, 1'b0, 1);
    push_d(1'b0, 64'hCAFE, 1'b0, 1);
    push_d(1'b1, 64'hCAFE, 1'b0, 1);
    i_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      d_req = 1'b1;
      while (d_req && n < 200) begin
        tick();
        n++;
      end
      chk("t3_dwait", n < 200, 1);
      tick();
    end
    wait_quiet("t3_timeout");
    // mem_rdy while idle is ignored
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    tick();
    chk("idle_rdy", {owner, i_done, d_done, err}, 0);
    // watchdog abort on a D read
    d_addr = 16'h2000; rdata_val = 64'hDEAD; rdy_lat = 0;
    push_g(1'b0, 16'h2000, 0);
    push_d(1'b1, 64'h0, 1'b1, 64);
    d_req = 1'b1;
    wait_quiet("t4_timeout");
    // mem_rdy on the last allowed cycle wins over the watchdog
    d_addr = 16'h2040; rdata_val = 64'h1234_5678_9ABC_DEF0; rdy_lat = 64;
    push_g(1'b0, 16'h2040, 0);
    push_d(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 64);
    d_req = 1'b1;
    wait_quiet("t5_timeout");
    // reset mid-transaction: silent abandon, then fresh grant right after release
    d_addr = 16'h3000; rdata_val = 64'h77; rdy_lat = 0;
    push_g(1'b0, 16'h3000, 0);
    d_req = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("t6_busy", owner, 2'b10);
    rst = 1'b0;
    tick();
    chk("t6_rst_zero", {mem_re, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_done, d_done, err, owner}, 0);
    rdy_lat = 2;
    push_g(1'b0, 16'h3000, 0);
    push_d(1'b1, 64'h77, 1'b0, 2);
    rst = 1'b1;
    tick();
    chk("t6_regrant", owner, 2'b10);
    wait_quiet("t6_timeout");
    chk("queues_empty", {g_q.size(), d_q.size()}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
